// File: rtl/parity_req_arbiter_pkg.sv
// Shared types for the parity request arbiter.
//   byte_fields_t : a data byte viewed as four 2-bit fields, x1 = [7:6] .. x4 = [1:0]
//   par_result_t  : parity / all-ones pair produced for one byte
//   res_state_t   : occupancy of the single-entry result register
package parity_arb_pkg;

  typedef struct packed {
    logic [1:0] x1;
    logic [1:0] x2;
    logic [1:0] x3;
    logic [1:0] x4;
  } byte_fields_t;

  typedef struct packed {
    logic parity;
    logic all_ones;
  } par_result_t;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_t;

endpackage

// File: rtl/parity_req_arbiter_if.sv
// Bus between the byte-producing requesters / result consumer and the arbiter.
//   req_valid[NUM_REQ]     : request pending, one bit per requester
//   req_data[NUM_REQ*8]    : byte of requester i at [8i+7:8i]
//   req_ready[NUM_REQ]     : one-hot (or zero) grant this cycle
//   res_valid / res_ready  : result handshake
//   res_id                 : requester index that produced the result
//   res_parity / res_all_ones : result bits
// master = requesters and consumer side, slave = arbiter side.
interface parity_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import parity_arb_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [ID_W-1:0]      res_id;
  logic                 res_parity;
  logic                 res_all_ones;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_parity, res_all_ones
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_parity, res_all_ones
  );

endinterface

// File: rtl/parity_req_arbiter_byte_parity_unit.sv
// Combinational parity / all-ones reduction of one byte.
//   fields : input byte as four 2-bit fields
//   result : parity (even parity bit, or odd-parity check bit when
//            PARITY_ARB_ODD_EN is defined) and all-ones flag
module byte_parity_unit
  import parity_arb_pkg::*;
(
  input  byte_fields_t fields,
  output par_result_t  result
);

  logic [7:0] bits;

  assign bits = {fields.x1, fields.x2, fields.x3, fields.x4};

`ifdef PARITY_ARB_ODD_EN
  assign result.parity = ~(^bits);
`else
  assign result.parity = ^bits;
`endif

  assign result.all_ones = &bits;

endmodule

// File: rtl/parity_req_arbiter.sv
// Round-robin front end sharing one byte parity/all-ones datapath among
// NUM_REQ requesters, with a single registered, id-tagged result slot.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : parity_req_arbiter_if.slave (request and result handshakes)
// Optional build macro: PARITY_ARB_ODD_EN (odd-parity check bit on res_parity).
module parity_req_arbiter
  import parity_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  parity_req_arbiter_if.slave   bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  res_state_t      state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0] res_id_reg;
  par_result_t     res_bits_reg;

  logic [7:0]      req_bytes [NUM_REQ];
  logic            free;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_id;
  logic            accept;
  byte_fields_t    granted_fields;
  par_result_t     unit_result;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // A held result blocks new grants; a result being popped frees the slot
  // in the same cycle so pop+push runs without bubbles.
  assign free = (state_reg == RES_EMPTY) || bus.res_ready;

  // First pending requester scanning from rr_ptr upward, modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_id     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_id = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[scan_id]) begin
        grant_found = 1'b1;
        grant_idx   = scan_id;
      end
    end
  end

  assign accept = free && grant_found && !rst;

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  // Only the granted byte reaches the datapath.
  assign granted_fields = byte_fields_t'(req_bytes[grant_idx]);

  byte_parity_unit u_parity (
    .fields (granted_fields),
    .result (unit_result)
  );

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      RES_EMPTY: if (accept) state_next = RES_FULL;
      RES_FULL:  if (bus.res_ready && !accept) state_next = RES_EMPTY;
      default:   state_next = RES_EMPTY;
    endcase
    if (accept) begin
      rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RES_EMPTY;
      rr_ptr_reg   <= '0;
      res_id_reg   <= '0;
      res_bits_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      if (accept) begin
        res_id_reg   <= grant_idx;
        res_bits_reg <= unit_result;
      end
    end
  end

  assign bus.res_valid    = (state_reg == RES_FULL);
  assign bus.res_id       = res_id_reg;
  assign bus.res_parity   = res_bits_reg.parity;
  assign bus.res_all_ones = res_bits_reg.all_ones;

endmodule

// File: tb/tb_parity_req_arbiter.sv
// Directed bench for parity_req_arbiter (NUM_REQ = 4). Expected values are
// hand-computed even-parity values, flipped when PARITY_ARB_ODD_EN is defined.
module tb_parity_req_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

`ifdef PARITY_ARB_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  always #5 clk = ~clk;

  parity_req_arbiter_if #(.NUM_REQ(4)) bus ();

  parity_req_arbiter #(.NUM_REQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One line per completed result transfer.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready)
      $display("txn: id=%0d parity=%0b all_ones=%0b", bus.res_id, bus.res_parity, bus.res_all_ones);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_data  = {8'h7F, 8'hFF, 8'h03, 8'h01};
    bus.res_ready = 1'b1;
    tick();
    tick();
    cmp_cnt++; if (bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    cmp_cnt++; if (bus.res_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
    cmp_cnt++; if (bus.res_id !== 2'd0) begin err_cnt++; $display("FAIL reset_res_id: got %0d expected 0", bus.res_id); end
    cmp_cnt++; if (bus.res_parity !== 1'b0) begin err_cnt++; $display("FAIL reset_res_parity: got %b expected 0", bus.res_parity); end
    cmp_cnt++; if (bus.res_all_ones !== 1'b0) begin err_cnt++; $display("FAIL reset_res_all_ones: got %b expected 0", bus.res_all_ones); end
    rst = 1'b0;
    #1;
    cmp_cnt++; if (bus.req_ready !== 4'b0001) begin err_cnt++; $display("FAIL reset_first_grant: got %b expected 0001", bus.req_ready); end
    bus.req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_single();
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b1;
    #1;
    cmp_cnt++; if (bus.req_ready !== 4'b0100) begin err_cnt++; $display("FAIL single_req_ready: got %b expected 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    cmp_cnt++; if (bus.res_valid !== 1'b1) begin err_cnt++; $display("FAIL single_res_valid: got %b expected 1", bus.res_valid); end
    cmp_cnt++; if (bus.res_id !== 2'd2) begin err_cnt++; $display("FAIL single_res_id: got %0d expected 2", bus.res_id); end
    cmp_cnt++; if (bus.res_parity !== (1'b0 ^ ODD)) begin err_cnt++; $display("FAIL single_parity: got %b expected %b", bus.res_parity, 1'b0 ^ ODD); end
    cmp_cnt++; if (bus.res_all_ones !== 1'b1) begin err_cnt++; $display("FAIL single_all_ones: got %b expected 1", bus.res_all_ones); end
    tick();
    cmp_cnt++; if (bus.res_valid !== 1'b0) begin err_cnt++; $display("FAIL single_drain: got %b expected 0", bus.res_valid); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_id [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       exp_par[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       exp_ao [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    bus.req_data  = {8'h7F, 8'hFF, 8'h03, 8'h01};
    bus.req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      tick();
      cmp_cnt++; if (bus.res_valid !== 1'b1) begin err_cnt++; $display("FAIL fair_valid[%0d]: got %b expected 1", i, bus.res_valid); end
      cmp_cnt++; if (bus.res_id !== exp_id[i]) begin err_cnt++; $display("FAIL fair_id[%0d]: got %0d expected %0d", i, bus.res_id, exp_id[i]); end
      cmp_cnt++; if (bus.res_parity !== (exp_par[i] ^ ODD)) begin err_cnt++; $display("FAIL fair_parity[%0d]: got %b expected %b", i, bus.res_parity, exp_par[i] ^ ODD); end
      cmp_cnt++; if (bus.res_all_ones !== exp_ao[i]) begin err_cnt++; $display("FAIL fair_all_ones[%0d]: got %b expected %b", i, bus.res_all_ones, exp_ao[i]); end
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req_data  = {8'h7F, 8'h00, 8'h01, 8'h01};
    bus.req_valid = 4'b0010;
    bus.res_ready = 1'b0;
    #1;
    cmp_cnt++; if (bus.req_ready !== 4'b0010) begin err_cnt++; $display("FAIL bp_first_grant: got %b expected 0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp_cnt++; if (bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0000", i, bus.req_ready); end
      cmp_cnt++; if (bus.res_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, bus.res_valid); end
      cmp_cnt++; if (bus.res_id !== 2'd1) begin err_cnt++; $display("FAIL bp_hold_id[%0d]: got %0d expected 1", i, bus.res_id); end
      cmp_cnt++; if (bus.res_parity !== (1'b1 ^ ODD)) begin err_cnt++; $display("FAIL bp_hold_parity[%0d]: got %b expected %b", i, bus.res_parity, 1'b1 ^ ODD); end
      cmp_cnt++; if (bus.res_all_ones !== 1'b0) begin err_cnt++; $display("FAIL bp_hold_all_ones[%0d]: got %b expected 0", i, bus.res_all_ones); end
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    cmp_cnt++; if (bus.req_ready !== 4'b0100) begin err_cnt++; $display("FAIL bp_release_grant: got %b expected 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    cmp_cnt++; if (bus.res_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_next_valid: got %b expected 1", bus.res_valid); end
    cmp_cnt++; if (bus.res_id !== 2'd2) begin err_cnt++; $display("FAIL bp_next_id: got %0d expected 2", bus.res_id); end
    cmp_cnt++; if (bus.res_parity !== (1'b0 ^ ODD)) begin err_cnt++; $display("FAIL bp_next_parity: got %b expected %b", bus.res_parity, 1'b0 ^ ODD); end
  endtask

  // Leaves a result pending on entry; requester 3 streams six bytes.
  task automatic test_back_to_back();
    logic [7:0] bytes  [6] = '{8'h01, 8'h00, 8'hFF, 8'h80, 8'h55, 8'hFE};
    logic       exp_par[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_ao [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      bus.req_data[31:24] = bytes[i];
      #1;
      cmp_cnt++; if (bus.req_ready !== 4'b1000) begin err_cnt++; $display("FAIL b2b_ready[%0d]: got %b expected 1000", i, bus.req_ready); end
      tick();
      cmp_cnt++; if (bus.res_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.res_valid); end
      cmp_cnt++; if (bus.res_id !== 2'd3) begin err_cnt++; $display("FAIL b2b_id[%0d]: got %0d expected 3", i, bus.res_id); end
      cmp_cnt++; if (bus.res_parity !== (exp_par[i] ^ ODD)) begin err_cnt++; $display("FAIL b2b_parity[%0d]: got %b expected %b", i, bus.res_parity, exp_par[i] ^ ODD); end
      cmp_cnt++; if (bus.res_all_ones !== exp_ao[i]) begin err_cnt++; $display("FAIL b2b_all_ones[%0d]: got %b expected %b", i, bus.res_all_ones, exp_ao[i]); end
    end
    bus.req_valid = '0;
    tick();
    cmp_cnt++; if (bus.res_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_drain: got %b expected 0", bus.res_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_data  = {8'h7F, 8'hFF, 8'h03, 8'h01};
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b0;
    tick();
    bus.req_valid = '0;
    cmp_cnt++; if (bus.res_valid !== 1'b1) begin err_cnt++; $display("FAIL mid_pending: got %b expected 1", bus.res_valid); end
    rst = 1'b1;
    bus.req_valid = 4'hF;
    #1;
    cmp_cnt++; if (bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL mid_rst_ready: got %b expected 0000", bus.req_ready); end
    tick();
    cmp_cnt++; if (bus.res_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_valid: got %b expected 0", bus.res_valid); end
    cmp_cnt++; if (bus.res_id !== 2'd0) begin err_cnt++; $display("FAIL mid_rst_id: got %0d expected 0", bus.res_id); end
    rst = 1'b0;
    bus.res_ready = 1'b1;
    #1;
    cmp_cnt++; if (bus.req_ready !== 4'b0001) begin err_cnt++; $display("FAIL mid_after_grant: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    cmp_cnt++; if (bus.res_valid !== 1'b1) begin err_cnt++; $display("FAIL mid_after_valid: got %b expected 1", bus.res_valid); end
    cmp_cnt++; if (bus.res_id !== 2'd0) begin err_cnt++; $display("FAIL mid_after_id: got %0d expected 0", bus.res_id); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parity_req_arbiter.md
# parity_req_arbiter

Round-robin front end that shares one byte parity/all-ones datapath among `NUM_REQ` requesters. Each requester offers an 8-bit byte over a valid/ready handshake. The arbiter grants one request per cycle and computes parity and all-ones on the granted byte. It returns a registered result tagged with the requester id, and the result is held under downstream backpressure. The block sits between byte-producing clients and the consumer of parity/status results.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester id; derived, not overridden.

Ports:
- `clk`: input, 1 bit, single clock; all logic is on the rising edge.
- `rst`: input, 1 bit, reset, synchronous, active-high.
- `req_valid`: input, `NUM_REQ` bits, one bit per requester; request pending.
- `req_data`: input, `NUM_REQ*8` bits, byte of requester i at bits [8i+7:8i].
- `req_ready`: output, `NUM_REQ` bits, one-hot or zero; grant/accept this cycle.
- `res_valid`: output, 1 bit, result available.
- `res_ready`: input, 1 bit, downstream accepts the result.
- `res_id`: output, `ID_W` bits, index of the requester that produced the result.
- `res_parity`: output, 1 bit, XOR of all 8 bits of the granted byte.
- `res_all_ones`: output, 1 bit, AND of all 8 bits of the granted byte.

## Operation
- Slot free: `free = !res_valid || res_ready`.
- Round-robin pointer `rr_ptr` (width `ID_W`) holds the highest-priority index. The search order is `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
- Grant: when `free`, assert `req_ready[g]` combinationally, where g is the first i in search order with `req_valid[i]=1`. When not free, or no request is pending, `req_ready` = 0.
- Acceptance: a transfer occurs when `req_valid[g] && req_ready[g]`. On acceptance:
  - the result register loads g, ^byte and &byte;
  - `res_valid` is set to 1;
  - `rr_ptr` is set to (g+1) mod `NUM_REQ`.
- Without acceptance, `rr_ptr` is unchanged.
- If `res_valid && res_ready` and there is no acceptance in the same cycle, `res_valid` clears to 0.
- Result outputs are stable while `res_valid=1 && res_ready=0`.
- Two-state view of the result register:
  - EMPTY: `res_valid=0`. Goes to FULL on acceptance.
  - FULL: `res_valid=1`. Stays FULL when (`res_ready=0`) or (`res_ready=1` with a new acceptance). Goes to EMPTY when `res_ready=1` with no acceptance.
- Requesters must hold `req_valid` and `req_data` until accepted. The arbiter does not sample `req_data` of requesters that are not granted.
- Byte field view: the byte is split into four 2-bit fields, x1=[7:6], x2=[5:4], x3=[3:2], x4=[1:0]. Parity and all-ones are reductions over the concatenation of these fields, which is equivalent to reducing all 8 bits.

## Timing
- Reset values: `res_valid`=0, `res_id`=0, `res_parity`=0, `res_all_ones`=0, `rr_ptr`=0.
- `req_ready` is 0 during the reset cycle.
- Latency: acceptance in cycle N gives the result visible in cycle N+1.
- Throughput: one result per cycle while `res_ready`=1. There are no bubbles on pop+push in the same cycle.
- Backpressure: `res_valid=1 && res_ready=0` forces all `req_ready`=0 in that cycle.
- Wrap: with g = `NUM_REQ`-1, `rr_ptr` returns to 0.
- Reset mid-operation: `rst` overrides everything. A pending result is discarded with no handshake, and `rr_ptr` returns to 0.

## Configuration
- `PARITY_ARB_ODD_EN`:
  - Defined: `res_parity` = ~(^byte), i.e. the odd-parity check bit.
  - Undefined: `res_parity` = ^byte, i.e. the even-parity bit.
- `res_all_ones` is unaffected by the macro.
- The reset value of `res_parity` is 0 in both builds.

## Structure
- Package `parity_arb_pkg`:
  - `byte_fields_t`, a packed struct {x1, x2, x3, x4}, each `logic [1:0]`;
  - `par_result_t`, a packed struct {parity, all_ones}.
- Sub-module `byte_parity_unit`: combinational, takes a `byte_fields_t`, outputs a `par_result_t`, and contains the macro-dependent parity inversion.
- The top level holds the round-robin grant logic, `rr_ptr` and the result register.

## Test plan
- Reset: hold `rst`=1 with `req_valid`=4'hF → `req_ready`=0, `res_valid`=0, all result outputs 0. After release, the first grant goes to requester 0.
- Single request: `req_valid`=4'b0100, byte 8'hFF, `res_ready`=1 → `req_ready`=4'b0100. Next cycle: `res_valid`=1, `res_id`=2, `res_parity`=0, `res_all_ones`=1.
- Fairness: `req_valid`=4'hF held for 6 cycles, `res_ready`=1 → `res_id` sequence 0,1,2,3,0,1 on consecutive cycles.
- Backpressure: result for id 1 pending with `res_ready`=0 for 3 cycles → `req_ready`=0 and outputs stable. Raise `res_ready` → same-cycle grant to id 2, result next cycle.
- Parity values: byte 8'h01 → parity 1, all_ones 0. With `PARITY_ARB_ODD_EN` defined → parity 0. Byte 8'h00 → parity 0 (1 with the macro).
- Reset mid-stream: assert `rst` while `res_valid`=1 and `rr_ptr`=3 → next cycle `res_valid`=0. After release, all requesting → first `res_id`=0.
